// File: rtl/hf_pkg.sv
// hf_pkg: shared state encoding, default threshold and sizing helper for the HF demodulator
package hf_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int EDGE_DETECT_THRESHOLD = 5;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/hf_deriv_filter.sv
// hf_deriv_filter: 4-deep sample history and 5-tap derivative, filt = (2*p4 + p3) - (2*x + p1)
module hf_deriv_filter
    import hf_pkg::*;
#(
    parameter int ADC_W = 8
)(
    input  logic                    osc_clk,
    input  logic                    reset,
    input  logic [ADC_W-1:0]        adc_d,
    output logic signed [ADC_W+2:0] filt
);
    logic [ADC_W-1:0] p1, p2, p3, p4;
    logic [ADC_W+2:0] pos, neg;

    always_ff @(negedge osc_clk) begin
        if (reset) begin
            {p1, p2, p3, p4} <= '0;
        end else begin
            p1 <= adc_d;
            p2 <= p1;
            p3 <= p2;
            p4 <= p3;
        end
    end

    // Both halves fit in ADC_W+2 bits, so the wrapped difference is the exact signed result.
    assign pos  = {2'b00, p4, 1'b0} + {3'b000, p3};
    assign neg  = {2'b00, adc_d, 1'b0} + {3'b000, p1};
    assign filt = $signed(pos - neg);
endmodule

// File: rtl/hf_subcarrier_demod.sv
// hf_subcarrier_demod: subcarrier load-modulation detector with framed SSP serialiser to the ARM
module hf_subcarrier_demod
    import hf_pkg::*;
#(
    parameter int ADC_W       = 8,
    parameter int SC_PERIOD   = 16,
    parameter int FRAME_BITS  = 8,
    parameter int RESET_PHASE = 3
)(
    input  logic             osc_clk,
    input  logic             reset,
    input  logic [ADC_W-1:0] adc_d,
    input  logic             listen_en,
    input  logic [ADC_W+2:0] threshold,
    output logic             curbit,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic             busy
);
    localparam int CW = clog2(SC_PERIOD * FRAME_BITS);
    localparam int PW = clog2(SC_PERIOD);
    localparam int EW = ADC_W + 4;
    localparam logic [CW-1:0] LAST      = CW'(SC_PERIOD * FRAME_BITS - 1);
    localparam logic [CW-1:0] FRAME_ON  = CW'(SC_PERIOD / 2 - 1);
    localparam logic [CW-1:0] FRAME_OFF = CW'(SC_PERIOD + SC_PERIOD / 2 - 1);
    localparam logic [PW-1:0] EVAL      = PW'(RESET_PHASE);
    localparam logic [PW-1:0] HALF      = PW'(SC_PERIOD / 2);

    state_t                  state, next;
    logic [CW-1:0]           cnt;
    logic [PW-1:0]           phase;
    logic [ADC_W+2:0]        thr;
    logic signed [ADC_W+2:0] filt, fall_max, rise_min;
    logic signed [EW-1:0]    thr_s;
    logic                    hit, filt_pos;

    hf_deriv_filter #(.ADC_W(ADC_W)) u_filt (
        .osc_clk(osc_clk),
        .reset  (reset),
        .adc_d  (adc_d),
        .filt   (filt)
    );

    assign phase    = cnt[PW-1:0];
    assign thr_s    = $signed({1'b0, thr});
    assign hit      = (EW'(fall_max) > thr_s) && (EW'(rise_min) < -thr_s);
    assign filt_pos = !filt[ADC_W+2] && (filt != '0);

    // Draining only ends on the last count of a frame so the ARM never sees a truncated frame.
    always_comb begin
        next = (state == IDLE) ? (listen_en ? RUN : IDLE) :
               listen_en       ? RUN :
               (state == RUN)  ? ((cnt == '0) ? IDLE : DRAIN) :
                                 ((cnt == LAST) ? IDLE : DRAIN);
    end

    always_ff @(negedge osc_clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            cnt      <= '0;
            thr      <= (ADC_W+3)'(EDGE_DETECT_THRESHOLD);
            fall_max <= '0;
            rise_min <= '0;
            {curbit, ssp_clk, ssp_frame, ssp_din} <= '0;
        end else begin
            state <= next;
            busy  <= (next != IDLE);
            if (next == IDLE) begin
                cnt      <= '0;
                fall_max <= '0;
                rise_min <= '0;
                {curbit, ssp_clk, ssp_frame, ssp_din} <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
                if (phase == EVAL) begin
                    curbit   <= hit;
                    thr      <= threshold;
                    fall_max <= '0;
                    rise_min <= '0;
                end else if (filt_pos) begin
                    if (filt > fall_max) fall_max <= filt;
                end else if (filt < rise_min) begin
                    rise_min <= filt;
                end
                if (phase == '0) begin
                    ssp_clk <= 1'b1;
                    ssp_din <= curbit;
                end
                if (phase == HALF) ssp_clk <= 1'b0;
                if (cnt == FRAME_ON) ssp_frame <= 1'b1;
                if (cnt == FRAME_OFF) ssp_frame <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hf_subcarrier_demod.sv
// tb_hf_subcarrier_demod: directed checks of filter/detector, SSP timing, FSM draining and generics
module tb_hf_subcarrier_demod;
    logic        osc_clk = 1'b1;
    logic        reset = 1'b1;
    logic [7:0]  adc_d = 8'd128;
    logic        listen_en = 1'b0;
    logic        listen_en2 = 1'b0;
    logic [10:0] threshold = 11'd5;
    logic        curbit, ssp_clk, ssp_frame, ssp_din, busy;
    logic        curbit2, ssp_clk2, ssp_frame2, ssp_din2, busy2;
    int          checks = 0;
    int          failures = 0;
    int          t = 0;

    always #5 osc_clk = ~osc_clk;

    hf_subcarrier_demod dut (
        .osc_clk(osc_clk), .reset(reset), .adc_d(adc_d), .listen_en(listen_en),
        .threshold(threshold), .curbit(curbit), .ssp_clk(ssp_clk),
        .ssp_frame(ssp_frame), .ssp_din(ssp_din), .busy(busy)
    );

    hf_subcarrier_demod #(.SC_PERIOD(32), .FRAME_BITS(4), .RESET_PHASE(5)) dut2 (
        .osc_clk(osc_clk), .reset(reset), .adc_d(adc_d), .listen_en(listen_en2),
        .threshold(threshold), .curbit(curbit2), .ssp_clk(ssp_clk2),
        .ssp_frame(ssp_frame2), .ssp_din(ssp_din2), .busy(busy2)
    );

    task automatic step();
        @(negedge osc_clk);
        #1;
        t++;
    endtask

    task automatic go_run();
        reset = 1'b1;
        listen_en = 1'b0;
        step();
        reset = 1'b0;
        listen_en = 1'b1;
        step();
    endtask

    function automatic logic [7:0] wave();
        return ((t / 8) % 2 != 0) ? 8'd160 : 8'd100;
    endfunction

    task automatic test_reset();
        logic [4:0] got;
        step();
        got = {curbit, ssp_clk, ssp_frame, ssp_din, busy};
        checks++;
        if (got !== 5'b0) begin failures++; $display("FAIL reset_initial got=%b exp=00000", got); end
        reset = 1'b0;
        listen_en = 1'b1;
        step();
        for (int c = 0; c <= 37; c++) step();
        checks++;
        if ({busy, ssp_clk} !== 2'b11) begin failures++; $display("FAIL reset_prerun busy/clk got=%b exp=11", {busy, ssp_clk}); end
        reset = 1'b1;
        step();
        got = {curbit, ssp_clk, ssp_frame, ssp_din, busy};
        checks++;
        if (got !== 5'b0) begin failures++; $display("FAIL reset_midrun got=%b exp=00000", got); end
        reset = 1'b0;
        listen_en = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_constant();
        logic [3:0] got, exp;
        int m;
        adc_d = 8'd128;
        threshold = 11'd5;
        go_run();
        for (int c = 0; c < 256; c++) begin
            step();
            m = c % 128;
            exp = {1'b0, (m % 16) < 8, (m >= 7 && m <= 22), 1'b1};
            got = {curbit, ssp_clk, ssp_frame, busy};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL constant c=%0d cur/clk/frame/busy got=%b exp=%b", c, got, exp); end
        end
    endtask

    task automatic test_square(input logic [10:0] thr, input logic exp);
        threshold = thr;
        adc_d = wave();
        go_run();
        for (int c = 0; c < 128; c++) begin
            adc_d = wave();
            step();
            if (c >= 19) begin
                checks++;
                if (curbit !== exp) begin failures++; $display("FAIL square thr=%0d c=%0d curbit got=%b exp=%b", thr, c, curbit, exp); end
            end
            if (c >= 32) begin
                checks++;
                if (ssp_din !== exp) begin failures++; $display("FAIL square thr=%0d c=%0d ssp_din got=%b exp=%b", thr, c, ssp_din, exp); end
            end
        end
    endtask

    task automatic test_boundary(input logic [10:0] thr, input logic exp);
        threshold = thr;
        adc_d = 8'd128;
        go_run();
        for (int c = 0; c < 80; c++) begin
            adc_d = (c >= 38 && c <= 43) ? 8'd130 : 8'd128;
            step();
            if (c >= 36 && c <= 50) begin
                checks++;
                if (curbit !== 1'b0) begin failures++; $display("FAIL boundary thr=%0d c=%0d curbit got=%b exp=0", thr, c, curbit); end
            end
            if (c == 51) begin
                checks++;
                if (curbit !== exp) begin failures++; $display("FAIL boundary_eval thr=%0d curbit got=%b exp=%b", thr, curbit, exp); end
            end
            if (c == 63) begin
                checks++;
                if (ssp_din !== 1'b0) begin failures++; $display("FAIL boundary_latency thr=%0d ssp_din got=%b exp=0", thr, ssp_din); end
            end
            if (c == 64) begin
                checks++;
                if (ssp_din !== exp) begin failures++; $display("FAIL boundary_din thr=%0d ssp_din got=%b exp=%b", thr, ssp_din, exp); end
            end
        end
    endtask

    task automatic test_drain();
        logic [4:0] got;
        threshold = 11'd5;
        adc_d = wave();
        go_run();
        for (int c = 0; c < 128; c++) begin
            adc_d = wave();
            listen_en = (c < 50);
            step();
            if (c >= 50 && c < 127) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL drain_busy c=%0d got=%b exp=1", c, busy); end
            end
            if (c == 100) begin
                checks++;
                if ({curbit, ssp_din} !== 2'b11) begin failures++; $display("FAIL drain_active cur/din got=%b exp=11", {curbit, ssp_din}); end
            end
        end
        got = {curbit, ssp_clk, ssp_frame, ssp_din, busy};
        checks++;
        if (got !== 5'b0) begin failures++; $display("FAIL drain_end got=%b exp=00000", got); end
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL drain_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got;
        threshold = 11'd5;
        adc_d = wave();
        go_run();
        for (int c = 0; c <= 256; c++) begin
            adc_d = wave();
            listen_en = (c < 50 || (c >= 90 && c < 256));
            step();
            if (c >= 50 && c < 256) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL reassert_busy c=%0d got=%b exp=1", c, busy); end
            end
            if (c == 134 || c == 135) begin
                checks++;
                if (ssp_frame !== (c == 135)) begin failures++; $display("FAIL reassert_frame c=%0d got=%b exp=%b", c, ssp_frame, c == 135); end
            end
            if (c == 200) begin
                checks++;
                if ({ssp_clk, ssp_din} !== 2'b01) begin failures++; $display("FAIL reassert_ssp clk/din got=%b exp=01", {ssp_clk, ssp_din}); end
            end
        end
        got = {curbit, ssp_clk, ssp_frame, ssp_din, busy};
        checks++;
        if (got !== 5'b0) begin failures++; $display("FAIL run_to_idle got=%b exp=00000", got); end
    endtask

    task automatic test_generic();
        logic [3:0] got, exp;
        int m;
        adc_d = 8'd128;
        threshold = 11'd5;
        reset = 1'b1;
        step();
        reset = 1'b0;
        listen_en2 = 1'b1;
        step();
        for (int c = 0; c < 256; c++) begin
            step();
            m = c % 128;
            exp = {1'b0, (m % 32) < 16, (m >= 15 && m <= 46), 1'b1};
            got = {curbit2, ssp_clk2, ssp_frame2, busy2};
            checks++;
            if (got !== exp) begin failures++; $display("FAIL generic c=%0d cur/clk/frame/busy got=%b exp=%b", c, got, exp); end
        end
        listen_en2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_constant();
        test_square(11'd5, 1'b1);
        test_square(11'd400, 1'b0);
        test_boundary(11'd6, 1'b0);
        test_boundary(11'd5, 1'b1);
        test_drain();
        test_back_to_back();
        test_generic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
